// File: rtl/ws2812_encoder.sv
// WS2812 one-wire serialiser: fetches 24-bit RGB words per LED through a request/address
// handshake and shifts them out GRB MSB-first as NRZ pulses, followed by a low latch period.
module ws2812_encoder #(
   parameter int  NUM_LEDS     = 8,
   parameter int  SYSTEM_CLOCK = 50000000,
   parameter int  RESET_US     = 60,
   localparam int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic          clk_i,
   input  logic          reset_i,
   input  logic          start_i,
   input  logic [AW:0]   led_count_i,
   output logic          busy_o,
   output logic          data_request_o,
   output logic [AW-1:0] address_or,
   input  logic [7:0]    red_i,
   input  logic [7:0]    green_i,
   input  logic [7:0]    blue_i,
   output logic          do_o
);

   localparam int T0H  = SYSTEM_CLOCK / 2500000;
   localparam int T1H  = SYSTEM_CLOCK / 1250000;
   localparam int TBIT = SYSTEM_CLOCK / 800000;
   localparam int TRST = (SYSTEM_CLOCK / 1000000) * RESET_US;
   localparam int TMAX = (TRST > TBIT) ? TRST : TBIT;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, NEXT, RST} state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic           r_phase;
   logic [TW-1:0]  r_tmr;
   logic [4:0]     r_bit;
   logic [23:0]    r_shift;
   logic [AW-1:0]  r_addr;
   logic [AW:0]    r_cnt;
   logic           r_do;
   logic           w_do_next;
   logic           w_tmr_last;
   logic           w_addr_last;
   logic [TW-1:0]  w_high;
   logic [AW:0]    w_start_cnt;

   assign w_start_cnt = (led_count_i > (AW+1)'(NUM_LEDS)) ? (AW+1)'(NUM_LEDS) : led_count_i;
   assign w_tmr_last  = (r_tmr == TW'(TBIT - 1));
   assign w_addr_last = ({1'b0, r_addr} == (r_cnt - (AW+1)'(1)));
   assign w_high      = r_shift[23] ? TW'(T1H) : TW'(T0H);

   assign busy_o         = (r_state != IDLE);
   assign data_request_o = (r_state == FETCH) && r_phase;
   assign address_or     = r_addr;
   assign do_o           = r_do;

   always_ff @(posedge clk_i) begin
      if (reset_i) r_state <= IDLE;
      else         r_state <= w_state_next;
   end

   // do_o is registered, so the line level for the upcoming cycle is decided here.
   always_comb begin
      w_state_next = r_state;
      w_do_next    = 1'b0;
      case (r_state)
         IDLE:  if (start_i) w_state_next = (w_start_cnt == '0) ? RST : FETCH;
         FETCH: if (r_phase) w_state_next = LATCH;
         LATCH: begin
            w_state_next = SEND;
            w_do_next    = 1'b1;
         end
         SEND: begin
            if (w_tmr_last) begin
               if (r_bit == 5'd0) w_state_next = NEXT;
               else               w_do_next    = 1'b1;
            end else begin
               w_do_next = ((r_tmr + TW'(1)) < w_high);
            end
         end
         NEXT:  w_state_next = w_addr_last ? RST : FETCH;
         RST:   if (r_tmr == TW'(TRST - 1)) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_phase <= 1'b0;
         r_tmr   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_addr  <= '0;
         r_cnt   <= '0;
         r_do    <= 1'b0;
      end else begin
         r_do <= w_do_next;
         case (r_state)
            IDLE: begin
               r_tmr   <= '0;
               r_phase <= 1'b0;
               if (start_i) begin
                  r_cnt  <= w_start_cnt;
                  r_addr <= '0;
               end
            end
            FETCH: r_phase <= ~r_phase;
            LATCH: begin
               r_shift <= {green_i, red_i, blue_i};
               r_bit   <= 5'd23;
               r_tmr   <= '0;
            end
            SEND: begin
               if (w_tmr_last) begin
                  r_tmr   <= '0;
                  r_shift <= {r_shift[22:0], 1'b0};
                  if (r_bit != 5'd0) r_bit <= r_bit - 5'd1;
               end else begin
                  r_tmr <= r_tmr + TW'(1);
               end
            end
            NEXT: begin
               r_tmr   <= '0;
               r_phase <= 1'b0;
               if (!w_addr_last) r_addr <= r_addr + AW'(1);
            end
            RST: r_tmr <= r_tmr + TW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ws2812_encoder.sv
// Directed bench for ws2812_encoder: decodes do_o pulse widths/periods, logs request addresses
// and busy windows, and compares them with hand-derived frame timing.
module tb_ws2812_encoder;

   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset_i = 1'b1;
   logic          start_i = 1'b0;
   logic [AW:0]   led_count_i = '0;
   logic          busy_o;
   logic          data_request_o;
   logic [AW-1:0] address_or;
   logic [7:0]    red_i, green_i, blue_i;
   logic          do_o;
   logic [23:0]   w_rgb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ws2812_encoder dut (
      .clk_i          (clk),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .led_count_i    (led_count_i),
      .busy_o         (busy_o),
      .data_request_o (data_request_o),
      .address_or     (address_or),
      .red_i          (red_i),
      .green_i        (green_i),
      .blue_i         (blue_i),
      .do_o           (do_o)
   );

   // LED memory model: address 0 holds R=00 G=FF B=01
   function automatic logic [23:0] grb(input int a);
      logic [7:0] r, g, b;
      r = 8'(a * 37);
      g = 8'(255 - a * 19);
      b = 8'(1 + a * 58);
      return {g, r, b};
   endfunction

   assign w_rgb   = grb(int'(address_or));
   assign green_i = w_rgb[23:16];
   assign red_i   = w_rgb[15:8];
   assign blue_i  = w_rgb[7:0];

   // event monitor, sampled on the falling edge
   int unsigned   cyc = 0;
   logic          prev_do = 1'b0;
   logic          prev_busy = 1'b0;
   int unsigned   rise_q[$];
   int unsigned   fall_q[$];
   int unsigned   brise_q[$];
   int unsigned   bfall_q[$];
   logic [AW-1:0] req_q[$];

   always @(negedge clk) begin
      if (do_o === 1'b1 && prev_do === 1'b0) rise_q.push_back(cyc);
      if (do_o === 1'b0 && prev_do === 1'b1) fall_q.push_back(cyc);
      if (busy_o === 1'b1 && prev_busy === 1'b0) brise_q.push_back(cyc);
      if (busy_o === 1'b0 && prev_busy === 1'b1) bfall_q.push_back(cyc);
      if (data_request_o === 1'b1) req_q.push_back(address_or);
      prev_do   = do_o;
      prev_busy = busy_o;
      cyc++;
   end

   int b_rise, b_fall, b_brise, b_bfall, b_req;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_rise  = rise_q.size();
      b_fall  = fall_q.size();
      b_brise = brise_q.size();
      b_bfall = bfall_q.size();
      b_req   = req_q.size();
   endtask

   // leaves the caller at the sample point of cycle 1 (start accepted on cycle 0 edge)
   task automatic start_frame(input logic [AW:0] cnt);
      @(negedge clk);
      snap();
      led_count_i = cnt;
      start_i     = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      while (busy_o !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle_reached"}, 32'(busy_o === 1'b0), 32'd1);
      @(negedge clk);
   endtask

   task automatic check_frame(input string tag, input int n);
      logic [31:0] exp_q[$];
      logic [23:0] w;
      int np, nf, nr, bad_gap, exp_gap;
      for (int i = 0; i < n; i++) begin
         w = grb(i);
         for (int b = 23; b >= 0; b--) exp_q.push_back(w[b] ? 32'd40 : 32'd20);
      end
      np = rise_q.size() - b_rise;
      nf = fall_q.size() - b_fall;
      nr = req_q.size() - b_req;
      check({tag, "_pulses"}, 32'(np), 32'(exp_q.size()));
      check({tag, "_falls"}, 32'(nf), 32'(exp_q.size()));
      for (int k = 0; k < np && k < nf && exp_q.size() > 0; k++) begin
         check({tag, "_high_len"}, fall_q[b_fall+k] - rise_q[b_rise+k], exp_q.pop_front());
      end
      bad_gap = 0;
      for (int k = 1; k < np; k++) begin
         exp_gap = (k % 24 == 0) ? 66 : 62;
         if (rise_q[b_rise+k] - rise_q[b_rise+k-1] != exp_gap) bad_gap++;
      end
      check({tag, "_bad_periods"}, 32'(bad_gap), 32'd0);
      check({tag, "_requests"}, 32'(nr), 32'(n));
      for (int k = 0; k < nr && k < n; k++) begin
         check({tag, "_req_addr"}, 32'(req_q[b_req+k]), 32'(k));
      end
      check({tag, "_busy_windows"}, 32'(bfall_q.size() - b_bfall), 32'd1);
      if (bfall_q.size() > b_bfall && brise_q.size() > b_brise) begin
         check({tag, "_busy_len"}, bfall_q[b_bfall] - brise_q[b_brise], 32'(n * 1492 + 3000));
         if (np > 0 && nf > 0) begin
            check({tag, "_first_rise"}, rise_q[b_rise] - brise_q[b_brise], 32'd3);
            check({tag, "_latch_tail"}, bfall_q[b_bfall] - fall_q[fall_q.size()-1], 32'd3023);
         end
      end
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bad;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_req", 32'(data_request_o), 32'd0);
      check("rst_addr", 32'(address_or), 32'd0);
      check("rst_do", 32'(do_o), 32'd0);
      reset_i = 1'b0;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (do_o !== 1'b0 || busy_o !== 1'b0 || data_request_o !== 1'b0 || address_or !== '0) bad++;
      end
      check("idle_bad_cycles", 32'(bad), 32'd0);

      // single LED: latency points, then full pulse train
      start_frame(4'd1);
      check("lat_c1_busy", 32'(busy_o), 32'd1);
      check("lat_c1_req", 32'(data_request_o), 32'd0);
      @(negedge clk);
      check("lat_c2_req", 32'(data_request_o), 32'd1);
      check("lat_c2_addr", 32'(address_or), 32'd0);
      @(negedge clk);
      check("lat_c3_req", 32'(data_request_o), 32'd0);
      check("lat_c3_do", 32'(do_o), 32'd0);
      @(negedge clk);
      check("lat_c4_do", 32'(do_o), 32'd1);
      wait_idle("one", 6000);
      check_frame("one", 1);

      start_frame(4'd8);
      wait_idle("eight", 20000);
      check_frame("eight", 8);

      start_frame(4'd12);
      wait_idle("clamp", 20000);
      check_frame("clamp", 8);

      start_frame(4'd0);
      check("zero_busy_c1", 32'(busy_o), 32'd1);
      wait_idle("zero", 4000);
      check_frame("zero", 0);

      // start pulses during SEND and during RST must be ignored
      start_frame(4'd2);
      repeat (100) @(negedge clk);
      led_count_i = 4'd5;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (3400) @(negedge clk);
      check("ign_in_rst_busy", 32'(busy_o), 32'd1);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_idle("ignore", 8000);
      check_frame("ignore", 2);
      start_frame(4'd1);
      wait_idle("after", 6000);
      check_frame("after", 1);

      // reset mid-bit of LED 3 (first bit of LED 3 is a '1', high at cycle 4500)
      start_frame(4'd8);
      repeat (4499) @(negedge clk);
      check("mid_addr", 32'(address_or), 32'd3);
      check("mid_do", 32'(do_o), 32'd1);
      reset_i = 1'b1;
      @(negedge clk);
      reset_i = 1'b0;
      check("abort_do", 32'(do_o), 32'd0);
      check("abort_busy", 32'(busy_o), 32'd0);
      check("abort_addr", 32'(address_or), 32'd0);
      check("abort_req", 32'(data_request_o), 32'd0);
      repeat (20) @(negedge clk);
      check("abort_quiet_reqs", 32'(req_q.size() - b_req), 32'd4);
      start_frame(4'd1);
      wait_idle("clean", 6000);
      check_frame("clean", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
